// File: rtl/bram_pixel_stream_in.sv
// Frame readback stage: streams DEPTH lattice pixels (9 direction values each) out of the
// direction BRAMs as one AXI4-Stream beat per pixel. Reads are credit-limited so that reads
// in flight plus beats held in the 4-entry output FIFO never exceed 4.
module bram_pixel_stream_in #(
  parameter int unsigned DATA_WIDTH             = 16,
  parameter int unsigned DEPTH                  = 2500,
  parameter int unsigned ADDRESS_WIDTH          = 12,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 144,
  parameter int unsigned READ_LATENCY           = 1
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  rd_en,
  output logic [ADDRESS_WIDTH-1:0]              rd_addr,
  input  logic [DATA_WIDTH-1:0]                 n_in,
  input  logic [DATA_WIDTH-1:0]                 null_in,
  input  logic [DATA_WIDTH-1:0]                 ne_in,
  input  logic [DATA_WIDTH-1:0]                 e_in,
  input  logic [DATA_WIDTH-1:0]                 se_in,
  input  logic [DATA_WIDTH-1:0]                 s_in,
  input  logic [DATA_WIDTH-1:0]                 sw_in,
  input  logic [DATA_WIDTH-1:0]                 w_in,
  input  logic [DATA_WIDTH-1:0]                 nw_in,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned INF_W      = 4;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic                               r_rd_en;
  logic                               w_rd_en_nxt;
  logic [ADDRESS_WIDTH-1:0]           r_rd_addr;
  logic [ADDRESS_WIDTH-1:0]           w_rd_addr_nxt;
  logic                               r_busy;
  logic                               r_done;
  logic [READ_LATENCY-1:0]            r_pipe_vld;
  logic [READ_LATENCY-1:0]            r_pipe_last;
  logic [CNT_W-1:0]                   r_outstanding;
  logic [CNT_W-1:0]                   r_count;
  logic [CNT_W-1:0]                   w_count_nxt;
  logic [CNT_W-1:0]                   w_wr_idx;
  logic [INF_W-1:0]                   w_inflight;
  logic                               w_credit;
  logic                               r_tvalid;
  logic                               w_push;
  logic                               w_push_last;
  logic                               w_pop;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]  w_rd_data;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]  r_fifo_data  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]              r_fifo_last;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]  w_shift_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]              w_shift_last;

  assign w_rd_data   = {nw_in, w_in, sw_in, s_in, se_in, e_in, ne_in, null_in, n_in};
  assign w_push      = r_pipe_vld[READ_LATENCY-1];
  assign w_push_last = r_pipe_last[READ_LATENCY-1];
  assign w_pop       = r_tvalid & m00_axis_tready;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_wr_idx    = w_pop ? (r_count - CNT_W'(1)) : r_count;
  // Everything already committed next cycle: outstanding reads, FIFO beats, the read on the bus.
  assign w_inflight  = INF_W'(r_outstanding) + INF_W'(r_count) + INF_W'(r_rd_en) - INF_W'(w_pop);
  assign w_credit    = (w_inflight < INF_W'(FIFO_DEPTH));

  assign busy            = r_busy;
  assign done            = r_done;
  assign rd_en           = r_rd_en;
  assign rd_addr         = r_rd_addr;
  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tdata  = r_fifo_data[0];
  assign m00_axis_tlast  = r_fifo_last[0];
  assign m00_axis_tstrb  = '1;

  // State register.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next read enable and next read address.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_en_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_rd_en) begin
          if (r_rd_addr == LAST_ADDR) begin
            w_state_nxt   = S_DRAIN;
            w_rd_addr_nxt = '0;
          end else begin
            w_rd_addr_nxt = r_rd_addr + ADDRESS_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        // The tagged last beat is always the final one; finish on its handshake.
        if (w_pop && r_fifo_last[0] && (r_outstanding == '0) && (w_count_nxt == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_rd_en_nxt = (w_state_nxt == S_ISSUE) && w_credit;
  end

  // Registered read port and status outputs.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_busy    <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  // Track each read through the BRAM latency together with its last-pixel tag.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_pipe_vld    <= '0;
      r_pipe_last   <= '0;
      r_outstanding <= '0;
    end else begin
      r_pipe_vld[0]  <= r_rd_en;
      r_pipe_last[0] <= r_rd_en && (r_rd_addr == LAST_ADDR);
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
      r_outstanding <= r_outstanding + CNT_W'(r_rd_en) - CNT_W'(w_push);
    end
  end

  // Shift-down view of the FIFO; the vacated top entry loses its last flag.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
      w_shift_data[i] = r_fifo_data[i+1];
      w_shift_last[i] = r_fifo_last[i+1];
    end
    w_shift_data[FIFO_DEPTH-1] = r_fifo_data[FIFO_DEPTH-1];
    w_shift_last[FIFO_DEPTH-1] = 1'b0;
  end

  // Output FIFO with the head always in entry 0, so tdata/tlast come straight from flops.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_count     <= '0;
      r_tvalid    <= 1'b0;
      r_fifo_last <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
      end
    end else begin
      r_count  <= w_count_nxt;
      r_tvalid <= (w_count_nxt != '0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_push && (w_wr_idx == CNT_W'(i))) begin
          r_fifo_data[i] <= w_rd_data;
          r_fifo_last[i] <= w_push_last;
        end else if (w_pop) begin
          r_fifo_data[i] <= w_shift_data[i];
          r_fifo_last[i] <= w_shift_last[i];
        end
      end
    end
  end

  // Credit accounting must never let a push land in a full FIFO.
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_aresetn) begin
      a_fifo_no_overflow: assert (!(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));
    end
  end

endmodule

// File: tb/tb_bram_pixel_stream_in.sv
// Bench for bram_pixel_stream_in: two instances (read latency 1 and 2) fed by behavioural
// BRAM models; expected beats are queued when a frame is started and popped on handshakes.
module tb_bram_pixel_stream_in;

  localparam int DEPTH = 2500;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 1 (READ_LATENCY=1)
  logic         start1, busy1, done1, rd_en1, tvalid1, tlast1, tready1;
  logic [11:0]  rd_addr1, b1_q;
  logic [143:0] tdata1;
  logic [17:0]  tstrb1;

  // Instance 2 (READ_LATENCY=2)
  logic         start2, busy2, done2, rd_en2, tvalid2, tlast2, tready2;
  logic [11:0]  rd_addr2, b2_q1, b2_q2;
  logic [143:0] tdata2;
  logic [17:0]  tstrb2;

  logic rand_rdy;

  bram_pixel_stream_in #(.READ_LATENCY(1)) dut1 (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start1), .busy(busy1),
    .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .n_in({4'd0, b1_q}), .null_in({4'd1, b1_q}), .ne_in({4'd2, b1_q}), .e_in({4'd3, b1_q}),
    .se_in({4'd4, b1_q}), .s_in({4'd5, b1_q}), .sw_in({4'd6, b1_q}), .w_in({4'd7, b1_q}),
    .nw_in({4'd8, b1_q}),
    .m00_axis_tvalid(tvalid1), .m00_axis_tdata(tdata1), .m00_axis_tstrb(tstrb1),
    .m00_axis_tlast(tlast1), .m00_axis_tready(tready1)
  );

  bram_pixel_stream_in #(.READ_LATENCY(2)) dut2 (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start2), .busy(busy2),
    .done(done2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .n_in({4'd0, b2_q2}), .null_in({4'd1, b2_q2}), .ne_in({4'd2, b2_q2}), .e_in({4'd3, b2_q2}),
    .se_in({4'd4, b2_q2}), .s_in({4'd5, b2_q2}), .sw_in({4'd6, b2_q2}), .w_in({4'd7, b2_q2}),
    .nw_in({4'd8, b2_q2}),
    .m00_axis_tvalid(tvalid2), .m00_axis_tdata(tdata2), .m00_axis_tstrb(tstrb2),
    .m00_axis_tlast(tlast2), .m00_axis_tready(tready2)
  );

  // BRAM models: word k holds lane j = {j, k}, so lane order and address are both visible.
  always @(posedge clk) begin
    if (rd_en1) b1_q <= rd_addr1;
    if (rd_en2) b2_q1 <= rd_addr2;
    b2_q2 <= b2_q1;
  end

  function automatic logic [144:0] exp_beat(input int k);
    logic [143:0] d;
    for (int j = 0; j < 9; j++) d[16*j +: 16] = {4'(j), 12'(k)};
    return {(k == DEPTH - 1), d};
  endfunction

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards and monitors
  logic [144:0] sb1[$];
  logic [144:0] sb2[$];
  logic [144:0] exp1, exp2;
  int beats1, first1, last1, dones1, done_cyc1, rdens;
  int beats2, first2, last2, dones2, done_cyc2;

  always @(negedge clk) begin
    if (tvalid1 && tready1) begin
      exp1 = (sb1.size() != 0) ? sb1.pop_front() : '1;
      check_eq("beat1", {tlast1, tdata1}, exp1);
      if (beats1 == 0) first1 = cyc;
      last1 = cyc;
      beats1++;
    end
    if (done1) begin
      dones1++;
      done_cyc1 = cyc;
    end
    if (tvalid2 && tready2) begin
      exp2 = (sb2.size() != 0) ? sb2.pop_front() : '1;
      check_eq("beat2", {tlast2, tdata2}, exp2);
      if (beats2 == 0) first2 = cyc;
      last2 = cyc;
      beats2++;
    end
    if (done2) begin
      dones2++;
      done_cyc2 = cyc;
    end
  end

  // 50% random ready when enabled
  always @(posedge clk) begin
    #1;
    if (rand_rdy) tready1 = 1'($urandom_range(0, 1));
  end

  // Start a frame on instance 1 (start high in cycle 0); returns in cycle 3.
  task automatic start_frame1(input bit lat);
    beats1 = 0; dones1 = 0; rdens = 0;
    for (int k = 0; k < DEPTH; k++) sb1.push_back(exp_beat(k));
    start1 = 1'b1;
    if (lat) check_eq("lat_c0_tvalid", tvalid1, 0);
    step(); start1 = 1'b0;
    if (rd_en1) rdens++;
    if (lat) begin
      check_eq("lat_c1_rd_en", rd_en1, 1);
      check_eq("lat_c1_rd_addr", rd_addr1, 0);
      check_eq("lat_c1_busy", busy1, 1);
    end
    step();
    if (rd_en1) rdens++;
    if (lat) check_eq("lat_c2_tvalid", tvalid1, 0);
    step();
    if (rd_en1) rdens++;
    if (lat) check_eq("lat_c3_tvalid", tvalid1, 1);
  endtask

  task automatic wait_done1();
    bit ok = 1'b0;
    for (int i = 0; i < 6 * DEPTH; i++) begin
      if (done1) begin ok = 1'b1; break; end
      step();
    end
    check_eq("done1_timeout", ok, 1);
  endtask

  task automatic frame_checks1(input bit consec);
    check_eq("frame1_beats", beats1, DEPTH);
    check_eq("frame1_sb_left", sb1.size(), 0);
    check_eq("frame1_done_pulses", dones1, 1);
    check_eq("frame1_done_after_last", done_cyc1, last1 + 1);
    check_eq("frame1_busy_after", busy1, 0);
    if (consec) check_eq("frame1_consecutive", last1 - first1, DEPTH - 1);
  endtask

  logic [144:0] b0;

  initial begin
    bit ok;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tready1 = 1'b1; tready2 = 1'b1; rand_rdy = 1'b0;
    beats1 = 0; beats2 = 0; dones1 = 0; dones2 = 0;
    repeat (3) step();

    // Reset state
    check_eq("rst_tvalid", tvalid1, 0);
    check_eq("rst_rd_en", rd_en1, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_done", done1, 0);
    check_eq("rst_tdata", tdata1, 0);
    check_eq("rst_tlast", tlast1, 0);
    check_eq("rst_rd_addr", rd_addr1, 0);
    check_eq("tstrb1", tstrb1, 18'h3FFFF);
    check_eq("tstrb2", tstrb2, 18'h3FFFF);
    rst_n = 1'b1;
    step(); step();

    // Full frame, tready high, latency 1
    start_frame1(1'b1);
    wait_done1();
    step();
    frame_checks1(1'b1);

    // Latency 2 instance
    beats2 = 0; dones2 = 0;
    for (int k = 0; k < DEPTH; k++) sb2.push_back(exp_beat(k));
    start2 = 1'b1;
    step(); start2 = 1'b0;
    check_eq("lat2_c1_rd_en", rd_en2, 1);
    check_eq("lat2_c1_rd_addr", rd_addr2, 0);
    check_eq("lat2_c1_busy", busy2, 1);
    step(); step();
    check_eq("lat2_c3_tvalid", tvalid2, 0);
    step();
    check_eq("lat2_c4_tvalid", tvalid2, 1);
    ok = 1'b0;
    for (int i = 0; i < 6 * DEPTH; i++) begin
      if (done2) begin ok = 1'b1; break; end
      step();
    end
    check_eq("done2_timeout", ok, 1);
    step();
    check_eq("frame2_beats", beats2, DEPTH);
    check_eq("frame2_sb_left", sb2.size(), 0);
    check_eq("frame2_done_pulses", dones2, 1);
    check_eq("frame2_done_after_last", done_cyc2, last2 + 1);
    check_eq("frame2_consecutive", last2 - first2, DEPTH - 1);

    // Backpressure: tready low for cycles 3..20
    b0 = exp_beat(0);
    start_frame1(1'b0);
    tready1 = 1'b0;
    for (int c = 3; c <= 20; c++) begin
      if (c > 3) begin
        step();
        if (rd_en1) rdens++;
      end
      check_eq("bp_tvalid", tvalid1, 1);
      check_eq("bp_hold_tdata", tdata1, b0[143:0]);
    end
    check_eq("bp_rd_en_count", rdens, 4);
    step();
    tready1 = 1'b1;
    wait_done1();
    step();
    frame_checks1(1'b0);

    // Random ready
    rand_rdy = 1'b1;
    start_frame1(1'b0);
    wait_done1();
    step();
    rand_rdy = 1'b0;
    tready1 = 1'b1;
    frame_checks1(1'b0);

    // start pulses during busy and during the done cycle are dropped
    start_frame1(1'b0);
    repeat (97) step();
    start1 = 1'b1;
    step(); start1 = 1'b0;
    wait_done1();
    start1 = 1'b1;
    step(); start1 = 1'b0;
    frame_checks1(1'b0);
    rdens = 0;
    repeat (10) begin
      step();
      if (rd_en1) rdens++;
    end
    check_eq("dropped_start_rd_en", rdens, 0);
    check_eq("dropped_start_busy", busy1, 0);
    check_eq("dropped_start_beats", beats1, DEPTH);
    check_eq("dropped_start_dones", dones1, 1);

    // Reset mid-frame at beat 1000 with tready low
    start_frame1(1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step();
      if (beats1 >= 1000) break;
    end
    tready1 = 1'b0;
    check_eq("pre_reset_beats", beats1, 1000);
    step(); step();
    check_eq("pre_reset_tvalid", tvalid1, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", tvalid1, 0);
    check_eq("mid_rst_rd_en", rd_en1, 0);
    check_eq("mid_rst_busy", busy1, 0);
    check_eq("mid_rst_tdata", tdata1, 0);
    check_eq("mid_rst_tlast", tlast1, 0);
    check_eq("mid_rst_rd_addr", rd_addr1, 0);
    check_eq("mid_rst_beats", beats1, 1000);
    sb1.delete();
    step(); step();
    rst_n = 1'b1;
    tready1 = 1'b1;
    step();
    start_frame1(1'b1);
    wait_done1();
    step();
    frame_checks1(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
